cnt_period_monitor: RTL
=======================

Name: cnt_period_monitor

Overview:
- Downstream consumer of the free-running 16-bit counter and its divisible-by-3 flag.
- Samples the counter value and hit flag each valid cycle, and detects counter wrap-around (value decreasing).
- For each completed count period, emits one statistics record through a small show-ahead FIFO with a valid/ready handshake.
- Sits between the counter stage and a host-side/logging consumer; overflow is reported, never stalls upstream.

Parameters:
CNT_W, 16, width of sampled counter value
ACC_W, 16, width of per-period length and hit accumulators
FIFO_DEPTH, 4, record FIFO entries (power of two, >=2)
DROP_W, 8, width of dropped-record counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  sample strobe; in_cnt/in_hit sampled when high
in_cnt  input  CNT_W  counter value from upstream
in_hit  input  1  upstream flag: in_cnt divisible by 3
clr  input  1  synchronous clear of overflow and drop_cnt
m_valid  output  1  record available
m_ready  input  1  downstream accepts record
m_len  output  ACC_W  samples in completed period
m_hits  output  ACC_W  samples with in_hit=1 in period
m_max  output  CNT_W  largest in_cnt seen in period
overflow  output  1  sticky: a record was dropped
drop_cnt  output  DROP_W  number of dropped records, saturating

Behaviour:
- Reset: state=IDLE; accumulators, last_cnt, FIFO pointers/count, FIFO storage cleared. m_valid=0, m_len=m_hits=m_max=0, overflow=0, drop_cnt=0. Reset mid-operation discards the open period and all queued records.
- States: IDLE (no sample since reset), ACCUM (period open).
- IDLE + in_valid: len=1, hits=in_hit, max=in_cnt, last_cnt=in_cnt, go to ACCUM. No record is emitted.
- ACCUM + in_valid, in_cnt >= last_cnt (no wrap): len+=1, hits+=in_hit, max=max(max,in_cnt), last_cnt=in_cnt. Equal values count as ordinary samples.
- ACCUM + in_valid, in_cnt < last_cnt (wrap):
  - Push record {len, hits, max} of the closed period. The wrapping sample is not included.
  - Same cycle, start a new period: len=1, hits=in_hit, max=in_cnt, last_cnt=in_cnt.
- in_valid=0: no state change.
- Accumulators saturate at all-ones and never wrap.
- FIFO and handshake:
  - Show-ahead FIFO; m_* reflect the head entry.
  - Pop when m_valid && m_ready.
  - m_valid rises the cycle after the wrap sample (1-cycle latency).
  - While m_valid && !m_ready, m_len/m_hits/m_max hold stable.
  - When empty, m_* hold their last values (0 after reset).
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted and count is unchanged.
  - Otherwise the record is dropped: overflow<=1, drop_cnt+=1 (saturating at all-ones). FIFO contents are unchanged.
- Simultaneous push and pop when not full: both happen; count unchanged.
- clr: overflow<=0, drop_cnt<=0 next cycle. Does not affect the FIFO or accumulators. If a drop and clr occur in the same cycle, clr wins.
- m_ready is ignored while m_valid=0.

Test Plan:
- Reset, then the counter runs 0..300 and wraps to 0, m_ready=1 -> one record: m_len=301, m_hits=101, m_max=300; m_valid high exactly 1 cycle after the in_cnt=0 sample.
- in_valid toggles 50% during 0..300..0 -> same record values (gaps do not count); a second wrap yields an identical second record.
- m_ready=0 with 5 wraps -> 4 records queued, 5th dropped: overflow=1, drop_cnt=1; release m_ready -> 4 records in order with stable data while stalled.
- FIFO full with m_ready=1 on the same cycle as a wrap -> push accepted, no drop, count stays at 4.
- Repeated in_cnt=7 for 70000 samples, then in_cnt=0 -> m_len saturates at 65535, m_max=7.
- Assert rst mid-period with 2 queued records -> m_valid=0 next cycle; the next wrap after re-entry emits only post-reset data. clr with overflow=1 -> overflow=0, drop_cnt=0.

Source files
------------

// File: rtl/cnt_period_monitor.sv
// -----------------------------------------------------------------------------
// cnt_period_monitor
//
// Watches the sample stream of a free-running counter and its divisible-by-3
// flag. A count period is closed when the counter value decreases (wrap). For
// every closed period one statistics record {len, hits, max} is queued in a
// small show-ahead FIFO. A valid/ready handshake drains the FIFO. The upstream
// side is never stalled. A record that finds the FIFO full is dropped, and the
// drop is reported through overflow/drop_cnt.
//
// Ports
//   clk       : clock, all logic on the rising edge
//   rst       : synchronous, active-high reset
//   in_valid  : sample strobe; in_cnt/in_hit are sampled when high
//   in_cnt    : counter value from upstream
//   in_hit    : upstream flag, in_cnt divisible by 3
//   clr       : synchronous clear of overflow and drop_cnt
//   m_valid   : record available at the FIFO head
//   m_ready   : downstream accepts the head record
//   m_len     : samples in the completed period
//   m_hits    : samples with in_hit=1 in the completed period
//   m_max     : largest in_cnt seen in the completed period
//   overflow  : sticky, at least one record was dropped
//   drop_cnt  : number of dropped records, saturating
// -----------------------------------------------------------------------------
module cnt_period_monitor #(
    parameter int CNT_W      = 16,
    parameter int ACC_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CNT_W-1:0]  in_cnt,
    input  logic              in_hit,
    input  logic              clr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_len,
    output logic [ACC_W-1:0]  m_hits,
    output logic [CNT_W-1:0]  m_max,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FILL_W = PTR_W + 1;
    localparam int REC_W  = 2 * ACC_W + CNT_W;
    localparam logic [FILL_W-1:0] DEPTH_C = FILL_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Increment by 'inc' (0 or 1), sticking at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] acc,
                                                 input logic             inc);
        logic [ACC_W-1:0] res;
        if (inc && (acc != {ACC_W{1'b1}})) begin
            res = acc + ACC_W'(1);
        end else begin
            res = acc;
        end
        return res;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;

    logic [ACC_W-1:0]   len_r;
    logic [ACC_W-1:0]   hits_r;
    logic [CNT_W-1:0]   max_r;
    logic [CNT_W-1:0]   last_r;

    logic               start_s;
    logic               accum_s;
    logic               wrap_s;

    logic [REC_W-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [FILL_W-1:0]  fill_r;
    logic [PTR_W-1:0]   wr_ptr_nxt_s;
    logic [PTR_W-1:0]   rd_ptr_nxt_s;
    logic [FILL_W-1:0]  fill_nxt_s;

    logic [REC_W-1:0]   rec_s;
    logic [REC_W-1:0]   head_nxt_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               accept_s;
    logic               drop_s;

    logic               m_valid_r;
    logic [ACC_W-1:0]   m_len_r;
    logic [ACC_W-1:0]   m_hits_r;
    logic [CNT_W-1:0]   m_max_r;
    logic               overflow_r;
    logic [DROP_W-1:0]  drop_cnt_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: leave IDLE on the first sample, then stay in ACCUM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                state_nxt_s = ST_ACCUM;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sample classification. A wrap closes the current period and also opens
    // a new one, so the wrapping sample goes into the new period.
    always_comb begin
        wrap_s  = 1'b0;
        accum_s = 1'b0;
        if (in_valid && (state_r == ST_ACCUM)) begin
            wrap_s  = (in_cnt < last_r);
            accum_s = (in_cnt >= last_r);
        end else begin
            wrap_s  = 1'b0;
            accum_s = 1'b0;
        end
        start_s = in_valid && ((state_r == ST_IDLE) || wrap_s);
        rec_s   = {len_r, hits_r, max_r};
    end

    // Per-period accumulators and the previous counter value.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r  <= {ACC_W{1'b0}};
            hits_r <= {ACC_W{1'b0}};
            max_r  <= {CNT_W{1'b0}};
            last_r <= {CNT_W{1'b0}};
        end else if (start_s) begin
            len_r  <= ACC_W'(1);
            hits_r <= {{(ACC_W-1){1'b0}}, in_hit};
            max_r  <= in_cnt;
            last_r <= in_cnt;
        end else if (accum_s) begin
            len_r  <= sat_inc(len_r, 1'b1);
            hits_r <= sat_inc(hits_r, in_hit);
            max_r  <= (in_cnt > max_r) ? in_cnt : max_r;
            last_r <= in_cnt;
        end else begin
            len_r  <= len_r;
            hits_r <= hits_r;
            max_r  <= max_r;
            last_r <= last_r;
        end
    end

    // FIFO control. A push into a full FIFO is still accepted when the head
    // is popped in the same cycle.
    always_comb begin
        push_s       = wrap_s;
        pop_s        = m_valid_r && m_ready;
        full_s       = (fill_r == DEPTH_C);
        accept_s     = push_s && (!full_s || pop_s);
        drop_s       = push_s && full_s && !pop_s;
        wr_ptr_nxt_s = accept_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        case ({accept_s, pop_s})
            2'b10:   fill_nxt_s = fill_r + FILL_W'(1);
            2'b01:   fill_nxt_s = fill_r - FILL_W'(1);
            default: fill_nxt_s = fill_r;
        endcase
        // The next head is the record being written when the FIFO is about
        // to hold only that record, otherwise it is already in storage.
        // An empty FIFO keeps showing the last head.
        if (fill_nxt_s == {FILL_W{1'b0}}) begin
            head_nxt_s = {m_len_r, m_hits_r, m_max_r};
        end else if (accept_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = rec_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage, pointers, fill level and registered head outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {REC_W{1'b0}};
            end
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            m_valid_r <= 1'b0;
            m_len_r   <= {ACC_W{1'b0}};
            m_hits_r  <= {ACC_W{1'b0}};
            m_max_r   <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= rec_s;
            end else begin
                mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
            end
            wr_ptr_r  <= wr_ptr_nxt_s;
            rd_ptr_r  <= rd_ptr_nxt_s;
            fill_r    <= fill_nxt_s;
            m_valid_r <= (fill_nxt_s != {FILL_W{1'b0}});
            {m_len_r, m_hits_r, m_max_r} <= head_nxt_s;
        end
    end

    // Overflow flag and drop counter. clr takes priority over a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (clr) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= (drop_cnt_r == {DROP_W{1'b1}}) ? drop_cnt_r
                                                          : (drop_cnt_r + DROP_W'(1));
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign m_valid  = m_valid_r;
    assign m_len    = m_len_r;
    assign m_hits   = m_hits_r;
    assign m_max    = m_max_r;
    assign overflow = overflow_r;
    assign drop_cnt = drop_cnt_r;

endmodule
